// File: rtl/c_gather_dyn_pkg.sv
// Shared helpers for the runtime-mask gather: ceiling log2 and population count.
package c_gather_dyn_pkg;

    // Ceiling log2; clog2(1) = 0, clog2(n+1) sizes a counter that can hold n.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(n)) r = r + 1;
        return r;
    endfunction

    // Number of set bits in a word of up to 64 bits.
    function automatic int unsigned pop_count(input logic [63:0] v);
        int unsigned c;
        c = 0;
        for (int i = 0; i < 64; i++) c = c + 32'(v[i]);
        return c;
    endfunction

endpackage

// File: rtl/c_gather_dyn_prefix_count.sv
// Exclusive prefix population count of a mask (log-depth Hillis-Steele scan) plus total.
module c_gather_dyn_prefix_count
    import c_gather_dyn_pkg::*;
#(
    parameter int unsigned in_width  = 32,
    parameter int unsigned cnt_width = clog2(in_width + 1)
) (
    input  logic [0:in_width-1]                 mask,
    output logic [in_width-1:0][cnt_width-1:0]  prefix,
    output logic [cnt_width-1:0]                total
);

    localparam int unsigned levels = clog2(in_width);

    logic [in_width-1:0][cnt_width-1:0] base;
    logic [in_width-1:0][cnt_width-1:0] incl;

    // Level 0: each bit contributes its own mask value.
    for (genvar i = 0; i < int'(in_width); i++) begin : g_base
        assign base[i] = cnt_width'(mask[i]);
    end

    // Level l adds the partial sum 2^l positions lower; after all levels it is inclusive.
    for (genvar l = 0; l < int'(levels); l++) begin : g_level
        logic [in_width-1:0][cnt_width-1:0] prev;
        logic [in_width-1:0][cnt_width-1:0] sum;
        if (l == 0) begin : g_first
            assign prev = base;
        end else begin : g_next
            assign prev = g_level[l-1].sum;
        end
        for (genvar i = 0; i < int'(in_width); i++) begin : g_bit
            if (i >= (1 << l)) begin : g_add
                assign sum[i] = prev[i] + prev[i - (1 << l)];
            end else begin : g_pass
                assign sum[i] = prev[i];
            end
        end
    end

    if (levels == 0) begin : g_flat
        assign incl = base;
    end else begin : g_scan
        assign incl = g_level[levels-1].sum;
    end

    // Exclusive count = inclusive count minus the bit itself.
    for (genvar i = 0; i < int'(in_width); i++) begin : g_excl
        assign prefix[i] = incl[i] - cnt_width'(mask[i]);
    end

    assign total = incl[in_width-1];

endmodule

// File: rtl/c_gather_dyn.sv
// Pipelined gather with a runtime mask: packs selected data bits toward index 0, reports count.
module c_gather_dyn
    import c_gather_dyn_pkg::*;
#(
    parameter  int unsigned in_width   = 32,
    parameter  int unsigned num_stages = 2,
    localparam int unsigned cnt_width  = clog2(in_width + 1)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [0:in_width-1]   data_in,
    input  logic [0:in_width-1]   mask_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [0:in_width-1]   data_out,
    output logic [0:cnt_width-1]  count_out
);

    logic                               ready_out;
    logic                               src_valid;
    logic [0:in_width-1]                src_data;
    logic [0:in_width-1]                src_mask;
    logic [in_width-1:0][cnt_width-1:0] in_prefix;
    logic [in_width-1:0][cnt_width-1:0] src_prefix;
    logic [cnt_width-1:0]               in_total;
    logic [cnt_width-1:0]               src_total;
    logic [0:in_width-1]                packed_c;

    c_gather_dyn_prefix_count #(
        .in_width  (in_width),
        .cnt_width (cnt_width)
    ) u_prefix (
        .mask   (mask_in),
        .prefix (in_prefix),
        .total  (in_total)
    );

    // Output register can take a new word when empty or being drained.
    assign ready_out = !out_valid || out_ready;

    if (num_stages == 1) begin : g_one
        // Single stage: prefix counts and scatter feed the output register directly.
        assign src_valid  = in_valid;
        assign src_data   = data_in;
        assign src_mask   = mask_in;
        assign src_prefix = in_prefix;
        assign src_total  = in_total;
        assign in_ready   = ready_out;
    end else begin : g_two
        logic                               valid_q;
        logic                               ready_q;
        logic [0:in_width-1]                data_q;
        logic [0:in_width-1]                mask_q;
        logic [in_width-1:0][cnt_width-1:0] prefix_q;
        logic [cnt_width-1:0]               total_q;

        // Empty stage loads even when the output is stalled (bubble collapse).
        assign ready_q  = !valid_q || ready_out;
        assign in_ready = ready_q;

        // Stage-0 occupancy.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                valid_q <= 1'b0;
            end else if (ready_q) begin
                valid_q <= in_valid;
            end
        end

        // Stage-0 payload: loaded only on an input transfer, no reset needed.
        always_ff @(posedge clk) begin
            if (ready_q && in_valid) begin
                data_q   <= data_in;
                mask_q   <= mask_in;
                prefix_q <= in_prefix;
                total_q  <= in_total;
            end
        end

        assign src_valid  = valid_q;
        assign src_data   = data_q;
        assign src_mask   = mask_q;
        assign src_prefix = prefix_q;
        assign src_total  = total_q;
    end

    // Scatter: output bit k collects the selected bit whose exclusive prefix equals k.
    // A bit at index i can only land at k <= i, so the inner loop starts at k.
    always_comb begin
        packed_c = '0;
        for (int k = 0; k < int'(in_width); k++) begin
            for (int i = k; i < int'(in_width); i++) begin
                packed_c[k] = packed_c[k] |
                    (src_data[i] & src_mask[i] & (src_prefix[i] == cnt_width'(k)));
            end
        end
    end

    // Output register: holds bit-stable while stalled, zero after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            data_out  <= '0;
            count_out <= '0;
        end else if (ready_out) begin
            out_valid <= src_valid;
            if (src_valid) begin
                data_out  <= packed_c;
                count_out <= src_total;
            end
        end
    end

endmodule

// File: tb/tb_c_gather_dyn.sv
// Directed and streamed checks for c_gather_dyn, plus a width/stage parameter sweep.
module tb_c_gather_dyn
    import c_gather_dyn_pkg::*;
;

    logic        clk;
    logic        reset_n;
    logic        sweep_rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [0:31] data_in;
    logic [0:31] mask_in;
    logic        out_valid;
    logic        out_ready;
    logic [0:31] data_out;
    logic [0:5]  count_out;

    int          vectors;
    int          miscompares;
    logic [9:0]  sweep_done;

    logic [0:31] fd [10];
    logic [0:31] fm [10];
    logic [0:63] mr;
    int unsigned mc;

    c_gather_dyn #(
        .in_width   (32),
        .num_stages (2)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .mask_in   (mask_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .count_out (count_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value and count it.
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference gather: walk the mask in index order, appending selected data bits.
    function automatic void pack_model(input logic [0:63] d, input logic [0:63] m,
                                       input int unsigned w,
                                       output logic [0:63] r, output int unsigned c);
        r = '0;
        c = 0;
        for (int i = 0; i < int'(w); i++) begin
            if (m[i]) begin
                r[c] = d[i];
                c++;
            end
        end
    endfunction

    function automatic int unsigned sw_width(input int unsigned c);
        case (c / 2)
            0:       return 1;
            1:       return 5;
            2:       return 8;
            3:       return 32;
            default: return 64;
        endcase
    endfunction

    // One word through the empty 2-stage main DUT with hand-computed expectations.
    task automatic single_word(input string tag, input logic [31:0] d, input logic [31:0] m,
                               input logic [31:0] exp_d, input int unsigned exp_c);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        data_in   = d;
        mask_in   = m;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({tag, "_lat1"}, 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_data"},  64'(data_out),  64'(exp_d));
        check({tag, "_count"}, 64'(count_out), 64'(exp_c));
        @(posedge clk); #1;
    endtask

    // Parameter sweep: latency check, then 100 streamed words under random back-pressure.
    for (genvar c = 0; c < 10; c++) begin : g_sw
        localparam int unsigned w  = sw_width(c);
        localparam int unsigned s  = 1 + (c % 2);
        localparam int unsigned cw = clog2(w + 1);

        logic          iv, ir, ov, rdy;
        logic [0:w-1]  di, mi, dout;
        logic [0:cw-1] cnt;
        bit            done;
        logic [0:63]   cur_d, cur_m, r;
        int unsigned   rc;
        logic [63:0]   q_d [$];
        int unsigned   q_c [$];
        logic [63:0]   held_d, held_c, exp_d;
        bit            held, pushed;
        int            sent, got, cyc;
        string         pfx;

        c_gather_dyn #(
            .in_width   (w),
            .num_stages (s)
        ) u_dut (
            .clk       (clk),
            .reset_n   (sweep_rst_n),
            .in_valid  (iv),
            .in_ready  (ir),
            .data_in   (di),
            .mask_in   (mi),
            .out_valid (ov),
            .out_ready (rdy),
            .data_out  (dout),
            .count_out (cnt)
        );

        assign sweep_done[c] = done;

        initial begin
            done = 1'b0;
            iv   = 1'b0;
            rdy  = 1'b0;
            di   = '0;
            mi   = '0;
            pfx  = $sformatf("w%0d_s%0d", w, s);
            wait (sweep_rst_n === 1'b1);
            @(posedge clk); #1;

            cur_d = {$urandom, $urandom};
            cur_m = {$urandom, $urandom};
            pack_model(cur_d, cur_m, w, r, rc);
            iv  = 1'b1;
            di  = cur_d[0:w-1];
            mi  = cur_m[0:w-1];
            rdy = 1'b1;
            @(posedge clk); #1;
            iv = 1'b0;
            repeat (s - 1) begin
                check({pfx, "_lat_early"}, 64'(ov), 64'd0);
                @(posedge clk); #1;
            end
            check({pfx, "_lat_valid"}, 64'(ov), 64'd1);
            check({pfx, "_lat_data"},  64'(dout), 64'(r[0:w-1]));
            check({pfx, "_lat_count"}, 64'(cnt), 64'(rc));
            @(posedge clk); #1;
            check({pfx, "_drained"}, 64'(ov), 64'd0);

            sent  = 0;
            got   = 0;
            cyc   = 0;
            held  = 1'b0;
            cur_d = {$urandom, $urandom};
            cur_m = {$urandom, $urandom};
            iv    = 1'b1;
            di    = cur_d[0:w-1];
            mi    = cur_m[0:w-1];
            rdy   = 1'($urandom_range(0, 1));
            while (got < 100 && cyc < 2000) begin
                @(negedge clk);
                if (held) begin
                    check({pfx, "_stall_valid"}, 64'(ov), 64'd1);
                    check({pfx, "_stall_data"},  64'(dout), held_d);
                    check({pfx, "_stall_count"}, 64'(cnt), held_c);
                end
                held   = ov && !rdy;
                held_d = 64'(dout);
                held_c = 64'(cnt);
                if (ov && rdy) begin
                    if (q_d.size() == 0) begin
                        check({pfx, "_extra_out"}, 64'(q_d.size()), 64'd1);
                    end else begin
                        exp_d = q_d.pop_front();
                        check({pfx, "_stream_data"},  64'(dout), exp_d);
                        check({pfx, "_stream_count"}, 64'(cnt), 64'(q_c.pop_front()));
                    end
                    got++;
                end
                pushed = 1'b0;
                if (iv && ir) begin
                    pack_model(cur_d, cur_m, w, r, rc);
                    q_d.push_back(64'(r[0:w-1]));
                    q_c.push_back(rc);
                    sent++;
                    pushed = 1'b1;
                end
                @(posedge clk); #1;
                if (pushed) begin
                    if (sent == 100) begin
                        iv = 1'b0;
                    end else begin
                        cur_d = {$urandom, $urandom};
                        cur_m = {$urandom, $urandom};
                        di    = cur_d[0:w-1];
                        mi    = cur_m[0:w-1];
                    end
                end
                rdy = 1'($urandom_range(0, 1));
                cyc++;
            end
            check({pfx, "_words_out"}, 64'(got), 64'd100);
            done = 1'b1;
        end
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset_n     = 1'b0;
        sweep_rst_n = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        data_in     = '0;
        mask_in     = '0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_data",      64'(data_out),  64'd0);
        check("rst_count",     64'(count_out), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        reset_n     = 1'b1;
        sweep_rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);

        single_word("basic",   32'hB600_0000, 32'hC300_0000, 32'hA000_0000, 4);
        single_word("mask0",   32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 0);
        single_word("mask1",   32'hDEAD_BEEF, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 32);
        single_word("bit31",   32'h0000_0001, 32'h0000_0001, 32'h8000_0000, 1);
        single_word("bit31z",  32'hFFFF_FFFE, 32'h0000_0001, 32'h0000_0000, 1);
        single_word("ends",    32'h8000_0001, 32'h8000_0001, 32'hC000_0000, 2);
        single_word("even",    32'hF0F0_F0F0, 32'hAAAA_AAAA, 32'hCCCC_0000, 16);

        // Two words in flight, then asynchronous reset between clock edges.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        data_in   = 32'hFFFF_FFFF;
        mask_in   = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        data_in = 32'h1234_5678;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("rst_mid_full",  64'(in_ready),  64'd0);
        check("rst_mid_valid", 64'(out_valid), 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_async_valid", 64'(out_valid), 64'd0);
        check("rst_async_data",  64'(data_out),  64'd0);
        check("rst_async_count", 64'(count_out), 64'd0);
        @(posedge clk); #1;
        reset_n   = 1'b1;
        out_ready = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            check("rst_no_stale", 64'(out_valid), 64'd0);
            check("rst_ready",    64'(in_ready),  64'd1);
        end
        single_word("post_rst", 32'h0F00_0000, 32'h0F00_0000, 32'hF000_0000, 4);

        // Fill the pipe while stalled, then accept in and out in the same cycles.
        for (int j = 0; j < 10; j++) begin
            fd[j] = $urandom;
            fm[j] = $urandom;
        end
        out_ready = 1'b0;
        in_valid  = 1'b1;
        data_in   = fd[0];
        mask_in   = fm[0];
        @(posedge clk); #1;
        data_in = fd[1];
        mask_in = fm[1];
        @(posedge clk); #1;
        check("full_in_ready_low", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        for (int j = 2; j < 10; j++) begin
            data_in = fd[j];
            mask_in = fm[j];
            #1;
            pack_model({fd[j-2], 32'h0}, {fm[j-2], 32'h0}, 32, mr, mc);
            check("full_in_ready", 64'(in_ready),  64'd1);
            check("full_valid",    64'(out_valid), 64'd1);
            check("full_data",     64'(data_out),  64'(mr[0:31]));
            check("full_count",    64'(count_out), 64'(mc));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        for (int j = 8; j < 10; j++) begin
            pack_model({fd[j], 32'h0}, {fm[j], 32'h0}, 32, mr, mc);
            check("drain_valid", 64'(out_valid), 64'd1);
            check("drain_data",  64'(data_out),  64'(mr[0:31]));
            check("drain_count", 64'(count_out), 64'(mc));
            @(posedge clk); #1;
        end
        check("drain_empty", 64'(out_valid), 64'd0);

        for (int t = 0; t < 5000 && sweep_done != 10'h3FF; t++) @(posedge clk);
        check("sweep_done", 64'(sweep_done), 64'h3FF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
